stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control FSM and mm:ss BCD timebase for the 4-digit seven-segment front panel. Takes three debounced single-cycle button pulses (start/stop, lap, clear), sequences a stopwatch through idle/run/pause/lap, and presents a 16-bit BCD word to the existing display scan logic. It replaces ad-hoc `cnt`-modulo counting with an explicit prescaler and a gated, wrap-safe BCD counter.

## Interface
- `TICK_DIV`, default 20_000_000: clk cycles per second tick (20 MHz board clock); legal range 2..2^27.
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start_stop`  in  1  one-cycle pulse from button debounce/edge detect.
- `lap`  in  1  one-cycle pulse.
- `clear`  in  1  one-cycle pulse.
- `disp_bcd`  out  16  {min_tens, min_ones, sec_tens, sec_ones}; each nibble 0..9, tens nibbles 0..5.
- `running`  out  1  high in RUN or LAP.
- `lap_active`  out  1  high in LAP (display frozen).
- `sec_tick`  out  1  one-cycle pulse, registered, on each count increment.
- `wrap`  out  1  one-cycle pulse, registered, when 59:59 rolls to 00:00.

## Operation
- States: IDLE, RUN, PAUSE, LAP. Reset → IDLE, count 00:00, prescaler 0, lap latch 00:00.
- Reset values: disp_bcd 16'h0000, running 0, lap_active 0, sec_tick 0, wrap 0.
- IDLE: start_stop → RUN; lap, clear ignored.
- RUN: start_stop → PAUSE; else lap → LAP and lap latch ← current count; clear ignored.
- LAP: start_stop → PAUSE; else lap → RUN; clear ignored. Counting continues in LAP.
- PAUSE: clear → IDLE, zeroes count and prescaler (clear beats start_stop); else start_stop → RUN; lap ignored.
- Pulse priority per state as listed; at most one transition per cycle.
- Prescaler advances only while the current (pre-edge) state is RUN or LAP; holds its value in PAUSE, so a resumed second keeps its partial progress.
- At prescaler == TICK_DIV-1 while counting: prescaler ← 0, count increments by one second, sec_tick asserted next cycle.
- BCD rules: sec_ones 9→0 carries to sec_tens; sec_tens 5→0 carries to min_ones; min_ones 9→0 carries to min_tens; 59:59 → 00:00 with wrap pulse alongside sec_tick. Counter keeps running after wrap.
- disp_bcd: lap latch when lap_active, else live count. Combinational from registers; no extra delay.
- Lap latch captures pre-edge count; if a tick coincides, the latched value excludes that increment.

## Timing
- Button pulse sampled at edge N; new state, running, lap_active visible after edge N.
- Increment decided by pre-edge state: a stop pulse coinciding with the wrap edge still increments.
- From IDLE, start at edge N: first increment at edge N+TICK_DIV; sec_tick high in the following cycle.
- Pause for k cycles: next increment delayed exactly k cycles.
- rst mid-operation: all state, count, latch, and outputs return to reset values on the next edge, overriding any pulse.

## Structure
- Shared package `clock_pkg`: state enum (IDLE, RUN, PAUSE, LAP; 2-bit), BCD digit width 4, `SEC_TENS_MAX` = 5, `DIGIT_MAX` = 9.
- Sub-module `tick_prescaler`: parameter TICK_DIV; inputs clk, rst, en, clr; output tick (one-cycle, combinational on terminal count). Count width is $clog2(TICK_DIV).
- BCD cascade and FSM stay in stopwatch_ctrl.

## Test plan
- TICK_DIV=4; reset, start, run 40 cycles → 10 sec_tick pulses, disp_bcd 16'h0010, running=1.
- Preload near wrap (run 3599 ticks) then one more tick → disp_bcd 16'h0000, wrap and sec_tick high the same cycle.
- Start, 2 cycles, stop, idle 10 cycles, start → next increment 2 cycles after restart; disp_bcd unchanged during pause.
- In RUN at 00:05, pulse lap → lap_active=1, disp_bcd holds 16'h0005 while 3 more ticks occur; lap again → disp_bcd 16'h0008.
- In PAUSE, start_stop and clear in the same cycle → IDLE, disp_bcd 16'h0000, running=0; clear in RUN → ignored.
- Assert rst while in LAP at 00:07 → next cycle all outputs at reset values; start then resumes from 00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the stopwatch front panel: FSM states,
// BCD digit limits and the mm:ss increment helper.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      LAP   = 2'd3
   } sw_state_t;

   localparam int          DIGIT_W      = 4;
   localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
   localparam logic [3:0]  DIGIT_MAX    = 4'd9;
   localparam logic [15:0] WRAP_VAL     = 16'h5959;

   // Advance a {min_tens, min_ones, sec_tens, sec_ones} word by one second,
   // rolling 59:59 over to 00:00.
   function automatic logic [15:0] bcd_inc(input logic [15:0] t);
      logic [DIGIT_W-1:0] so;
      logic [DIGIT_W-1:0] st;
      logic [DIGIT_W-1:0] mo;
      logic [DIGIT_W-1:0] mt;
      so = t[3:0];
      st = t[7:4];
      mo = t[11:8];
      mt = t[15:12];
      if (so != DIGIT_MAX) begin
         so = so + 4'd1;
      end else begin
         so = 4'd0;
         if (st != SEC_TENS_MAX) begin
            st = st + 4'd1;
         end else begin
            st = 4'd0;
            if (mo != DIGIT_MAX) begin
               mo = mo + 4'd1;
            end else begin
               mo = 4'd0;
               if (mt != SEC_TENS_MAX) begin
                  mt = mt + 4'd1;
               end else begin
                  mt = 4'd0;
               end
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, display word and status pulses out.
interface stopwatch_ctrl_if;
   logic        start_stop;
   logic        lap;
   logic        clear;
   logic [15:0] disp_bcd;
   logic        running;
   logic        lap_active;
   logic        sec_tick;
   logic        wrap;

   modport master (
      output start_stop, lap, clear,
      input  disp_bcd, running, lap_active, sec_tick, wrap
   );

   modport slave (
      input  start_stop, lap, clear,
      output disp_bcd, running, lap_active, sec_tick, wrap
   );
endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while en is low so a paused second keeps its progress.
module tick_prescaler #(
   parameter int TICK_DIV = 20_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int             CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0]  TERM = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_r;

   assign tick = en && (cnt_r == TERM);

   // Prescale counter: wraps on terminal count, holds when disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (tick) begin
         cnt_r <= '0;
      end else if (en) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM plus mm:ss BCD counter and lap latch.
// The display shows the lap latch while in LAP, otherwise the live count.
module stopwatch_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 20_000_000
) (
   input  logic              clk,
   input  logic              rst,
   stopwatch_ctrl_if.slave   bus
);
   sw_state_t   state_r;
   sw_state_t   next_state_s;
   logic        lap_capture_s;
   logic        clear_cnt_s;
   logic        counting_s;
   logic        tick_s;
   logic [15:0] count_r;
   logic [15:0] lap_r;
   logic        running_r;
   logic        lap_active_r;
   logic        sec_tick_r;
   logic        wrap_r;

   // Counting is decided by the pre-edge state, so a stop pulse on a tick
   // edge still lets that increment through.
   assign counting_s = (state_r == RUN) || (state_r == LAP);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (counting_s),
      .clr  (clear_cnt_s),
      .tick (tick_s)
   );

   // Next-state and side-effect decode; pulse priority follows state order.
   always_comb begin
      next_state_s  = state_r;
      lap_capture_s = 1'b0;
      clear_cnt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start_stop) begin
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (bus.start_stop) begin
               next_state_s = PAUSE;
            end else if (bus.lap) begin
               next_state_s  = LAP;
               lap_capture_s = 1'b1;
            end else begin
               next_state_s = RUN;
            end
         end
         LAP: begin
            if (bus.start_stop) begin
               next_state_s = PAUSE;
            end else if (bus.lap) begin
               next_state_s = RUN;
            end else begin
               next_state_s = LAP;
            end
         end
         PAUSE: begin
            if (bus.clear) begin
               next_state_s = IDLE;
               clear_cnt_s  = 1'b1;
            end else if (bus.start_stop) begin
               next_state_s = RUN;
            end else begin
               next_state_s = PAUSE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State register with status flags decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         running_r    <= 1'b0;
         lap_active_r <= 1'b0;
      end else begin
         state_r      <= next_state_s;
         running_r    <= (next_state_s == RUN) || (next_state_s == LAP);
         lap_active_r <= (next_state_s == LAP);
      end
   end

   // Live mm:ss count; clear and tick can never coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= 16'h0000;
      end else if (clear_cnt_s) begin
         count_r <= 16'h0000;
      end else if (tick_s) begin
         count_r <= bcd_inc(count_r);
      end else begin
         count_r <= count_r;
      end
   end

   // Lap latch captures the pre-edge count, excluding a coincident tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         lap_r <= 16'h0000;
      end else if (lap_capture_s) begin
         lap_r <= count_r;
      end else begin
         lap_r <= lap_r;
      end
   end

   // One-cycle status pulses, delayed one cycle after the increment edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_tick_r <= 1'b0;
         wrap_r     <= 1'b0;
      end else begin
         sec_tick_r <= tick_s;
         wrap_r     <= tick_s && (count_r == WRAP_VAL);
      end
   end

   assign bus.disp_bcd   = lap_active_r ? lap_r : count_r;
   assign bus.running    = running_r;
   assign bus.lap_active = lap_active_r;
   assign bus.sec_tick   = sec_tick_r;
   assign bus.wrap       = wrap_r;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4. Expected tick events are
// queued by the stimulus; a monitor checks each sec_tick against the queue.
module tb_stopwatch_ctrl;
   localparam int TD = 4;

   typedef struct packed {
      logic [15:0] disp;
      logic        wrap;
      logic        lap_active;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   exp_t sb_q[$];

   stopwatch_ctrl_if bus ();

   stopwatch_ctrl #(.TICK_DIV(TD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent seconds-to-mm:ss BCD conversion.
   function automatic logic [15:0] to_bcd(input int secs);
      int s, m, x;
      s = secs % 3600;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_tick(input int secs, input logic lapped, input logic [15:0] latched);
      exp_t e;
      e.disp       = lapped ? latched : to_bcd(secs);
      e.wrap       = (secs % 3600 == 0) ? 1'b1 : 1'b0;
      e.lap_active = lapped;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input logic ss, input logic lp, input logic cl);
      bus.start_stop = ss;
      bus.lap        = lp;
      bus.clear      = cl;
      @(negedge clk);
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
   endtask

   task automatic stop_clear(input string name);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      check({name, "_cleared_disp"}, 32'(bus.disp_bcd), 32'h0000);
      check({name, "_cleared_running"}, 32'(bus.running), 32'd0);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 64) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain"}, 32'(sb_q.size()), 32'd0);
   endtask

   // Scoreboard monitor: every sec_tick must match the oldest expectation.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.sec_tick === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_tick", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("tick_disp", 32'(bus.disp_bcd), 32'(e.disp));
               check("tick_wrap", 32'(bus.wrap), 32'(e.wrap));
               check("tick_lap_active", 32'(bus.lap_active), 32'(e.lap_active));
            end
         end else if (bus.wrap === 1'b1) begin
            check("wrap_without_tick", 32'(bus.wrap), 32'd0);
         end
      end
   end

   // Watchdog.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.start_stop = 1'b0;
      bus.lap        = 1'b0;
      bus.clear      = 1'b0;
      idle(3);
      check("rst_disp", 32'(bus.disp_bcd), 32'h0000);
      check("rst_running", 32'(bus.running), 32'd0);
      check("rst_lap_active", 32'(bus.lap_active), 32'd0);
      check("rst_sec_tick", 32'(bus.sec_tick), 32'd0);
      check("rst_wrap", 32'(bus.wrap), 32'd0);
      rst = 1'b0;
      idle(2);

      // Lap and clear ignored in IDLE.
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      check("idle_ignore_running", 32'(bus.running), 32'd0);
      check("idle_ignore_lap", 32'(bus.lap_active), 32'd0);

      // 40 cycles of running gives ten seconds.
      for (int i = 1; i <= 10; i++) push_tick(i, 1'b0, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(40);
      check("run40_disp", 32'(bus.disp_bcd), 32'h0010);
      check("run40_running", 32'(bus.running), 32'd1);
      drain("run40");
      stop_clear("run40");

      // Full hour: last tick wraps to 00:00.
      for (int i = 1; i <= 3600; i++) push_tick(i, 1'b0, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(TD * 3600);
      check("wrap_disp", 32'(bus.disp_bcd), 32'h0000);
      check("wrap_pulse", 32'(bus.wrap), 32'd1);
      check("wrap_sec_tick", 32'(bus.sec_tick), 32'd1);
      drain("wrap");
      stop_clear("wrap");

      // Pause keeps partial prescaler progress.
      push_tick(1, 1'b0, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(1);
      pulse(1'b1, 1'b0, 1'b0);
      check("pause_running", 32'(bus.running), 32'd0);
      idle(10);
      check("pause_disp_hold", 32'(bus.disp_bcd), 32'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(1);
      check("resume_no_tick_yet", 32'(bus.sec_tick), 32'd0);
      idle(1);
      check("resume_tick", 32'(bus.sec_tick), 32'd1);
      check("resume_disp", 32'(bus.disp_bcd), 32'h0001);
      drain("pause");
      stop_clear("pause");

      // Lap freezes display at 00:05 while counting continues.
      for (int i = 1; i <= 5; i++) push_tick(i, 1'b0, 16'h0000);
      for (int i = 6; i <= 8; i++) push_tick(i, 1'b1, 16'h0005);
      pulse(1'b1, 1'b0, 1'b0);
      idle(20);
      check("lap_pre_disp", 32'(bus.disp_bcd), 32'h0005);
      pulse(1'b0, 1'b1, 1'b0);
      check("lap_active_on", 32'(bus.lap_active), 32'd1);
      check("lap_running", 32'(bus.running), 32'd1);
      idle(11);
      check("lap_frozen_disp", 32'(bus.disp_bcd), 32'h0005);
      pulse(1'b0, 1'b1, 1'b0);
      check("lap_release_disp", 32'(bus.disp_bcd), 32'h0008);
      check("lap_active_off", 32'(bus.lap_active), 32'd0);
      drain("lap");
      stop_clear("lap");

      // Clear ignored in RUN; clear beats start_stop in PAUSE.
      push_tick(1, 1'b0, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(4);
      pulse(1'b0, 1'b0, 1'b1);
      check("run_clear_ignored_running", 32'(bus.running), 32'd1);
      check("run_clear_ignored_disp", 32'(bus.disp_bcd), 32'h0001);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b1);
      check("pause_clear_disp", 32'(bus.disp_bcd), 32'h0000);
      check("pause_clear_running", 32'(bus.running), 32'd0);
      idle(2);
      check("pause_clear_idle", 32'(bus.running), 32'd0);
      push_tick(1, 1'b0, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(3);
      check("presc_cleared_no_early_tick", 32'(bus.sec_tick), 32'd0);
      idle(1);
      check("presc_cleared_tick", 32'(bus.sec_tick), 32'd1);
      check("presc_cleared_disp", 32'(bus.disp_bcd), 32'h0001);
      drain("clear");
      stop_clear("clear");

      // Reset while in LAP at 00:07 overrides a coincident lap pulse.
      for (int i = 1; i <= 7; i++) push_tick(i, 1'b0, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(28);
      check("lap7_disp", 32'(bus.disp_bcd), 32'h0007);
      pulse(1'b0, 1'b1, 1'b0);
      check("lap7_active", 32'(bus.lap_active), 32'd1);
      drain("lap7");
      rst     = 1'b1;
      bus.lap = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      bus.lap = 1'b0;
      check("mid_rst_disp", 32'(bus.disp_bcd), 32'h0000);
      check("mid_rst_running", 32'(bus.running), 32'd0);
      check("mid_rst_lap_active", 32'(bus.lap_active), 32'd0);
      check("mid_rst_sec_tick", 32'(bus.sec_tick), 32'd0);
      check("mid_rst_wrap", 32'(bus.wrap), 32'd0);
      idle(6);
      check("post_rst_idle", 32'(bus.running), 32'd0);
      push_tick(1, 1'b0, 16'h0000);
      pulse(1'b1, 1'b0, 1'b0);
      idle(4);
      check("post_rst_resume_disp", 32'(bus.disp_bcd), 32'h0001);
      check("post_rst_resume_tick", 32'(bus.sec_tick), 32'd1);
      drain("post_rst");
      stop_clear("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
